// File: rtl/uart_transmitter_fifo_if.sv
// uart_transmitter_fifo_if: ready/valid character push channel into the UART transmit FIFO.
interface uart_transmitter_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 data_in_valid;
    logic                 data_in_ready;
    modport master (output data_in, data_in_valid, input data_in_ready);
    modport slave (input data_in, data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_transmitter_fifo.sv
// uart_transmitter_fifo: FIFO-buffered UART transmitter with configurable data bits, parity and stop bits.
module uart_transmitter_fifo #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_transmitter_fifo_if.slave      in_if,
    output logic                        serial_out,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = SYMBOL_EDGE_TIME > 1 ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CLK = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 serial_q, serial_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic [DATA_BITS-1:0] head;
    logic                 empty, full, fire, pop, bit_end;

    assign head = mem_q[rd_ptr_q];
    assign empty = count_q == '0;
    assign full = count_q == DEPTH;
    assign fire = in_if.data_in_valid && !full;
    assign bit_end = clk_cnt_q == LAST_CLK;
    // Popping at the end of the last stop bit chains frames with no idle gap.
    assign pop = !empty && (state_q == S_IDLE || (state_q == S_STOP && bit_end && bit_idx_q == LAST_STOP));
    assign in_if.data_in_ready = !full;
    assign serial_out = serial_q;
    assign tx_busy = state_q != S_IDLE || !empty;
    assign fifo_count = count_q;

    always_comb begin
        state_d = state_q;
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d = shift_q;
        parity_d = parity_q;
        case (state_q)
            S_IDLE: clk_cnt_d = '0;
            S_START: if (bit_end) begin
                state_d = S_DATA;
                bit_idx_d = '0;
            end
            S_DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_idx_d = bit_idx_q + 1'b1;
                if (bit_idx_q == LAST_DATA) begin
                    state_d = PARITY != 0 ? S_PARITY : S_STOP;
                    bit_idx_d = '0;
                end
            end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP: if (bit_end) begin
                bit_idx_d = bit_idx_q + 1'b1;
                if (bit_idx_q == LAST_STOP) begin
                    state_d = S_IDLE;
                    bit_idx_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            state_d = S_START;
            clk_cnt_d = '0;
            shift_d = head;
            parity_d = ^head ^ (PARITY == 2);
        end
        // The line level is registered from the next state so it cannot glitch mid-bit.
        serial_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? shift_d[0] : state_d == S_PARITY ? parity_d : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q <= shift_d;
            parity_q <= parity_d;
            serial_q <= serial_d;
            if (fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW + 1)'(fire) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (fire) mem_q[wr_ptr_q] <= in_if.data_in;
    end
endmodule

// File: tb/tb_uart_transmitter_fifo.sv
// tb_uart_transmitter_fifo: three frame formats (8N1/depth 4, 7E2, 8O1) checked every cycle
// against a frame-level model built from the line protocol, plus directed scenarios.
`timescale 1ns/1ps
module tb_uart_transmitter_fifo;
    localparam int SET = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] vld = '0;
    logic [7:0] dat [3];
    wire  [2:0] ser, bsy, rdy;
    wire  [2:0] fc0;
    wire  [3:0] fc1, fc2;
    int         errors = 0;
    int         checks = 0;
    bit         chk_en = 1'b0;

    int m_cnt [3];
    int m_hd [3];
    int m_pos [3];
    int m_len [3];
    int m_byte [3];
    bit m_act [3];
    int m_q [3][16];

    always #5 clk = ~clk;

    uart_transmitter_fifo_if #(.DATA_BITS(8)) if0 ();
    uart_transmitter_fifo_if #(.DATA_BITS(7)) if1 ();
    uart_transmitter_fifo_if #(.DATA_BITS(8)) if2 ();

    assign if0.data_in = dat[0];
    assign if0.data_in_valid = vld[0];
    assign rdy[0] = if0.data_in_ready;
    assign if1.data_in = dat[1][6:0];
    assign if1.data_in_valid = vld[1];
    assign rdy[1] = if1.data_in_ready;
    assign if2.data_in = dat[2];
    assign if2.data_in_valid = vld[2];
    assign rdy[2] = if2.data_in_ready;

    uart_transmitter_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset(reset), .in_if(if0), .serial_out(ser[0]), .tx_busy(bsy[0]), .fifo_count(fc0));
    uart_transmitter_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(8)) u1 (
        .clk(clk), .reset(reset), .in_if(if1), .serial_out(ser[1]), .tx_busy(bsy[1]), .fifo_count(fc1));
    uart_transmitter_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)) u2 (
        .clk(clk), .reset(reset), .in_if(if2), .serial_out(ser[2]), .tx_busy(bsy[2]), .fifo_count(fc2));

    function automatic int dbits(input int k);
        return k == 1 ? 7 : 8;
    endfunction

    function automatic int pmode(input int k);
        return k == 0 ? 0 : k == 1 ? 1 : 2;
    endfunction

    function automatic int sbits(input int k);
        return k == 1 ? 2 : 1;
    endfunction

    function automatic int depth(input int k);
        return k == 0 ? 4 : 8;
    endfunction

    // Bit j of the frame carrying byte b: start, LSB-first payload, optional parity, stop bits.
    function automatic logic frame_bit(input int k, input int b, input int j);
        int db = dbits(k);
        int ones = $countones(b & ((1 << db) - 1));
        if (j == 0) return 1'b0;
        if (j <= db) return b[j-1];
        if (pmode(k) != 0 && j == db + 1) return ((ones + (pmode(k) == 2 ? 1 : 0)) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        bit f;
        if (reset) begin
            m_act[k] = 1'b0;
            m_cnt[k] = 0;
            m_hd[k] = 0;
            m_pos[k] = 0;
            return;
        end
        f = vld[k] && m_cnt[k] < depth(k);
        if (m_act[k]) begin
            m_pos[k]++;
            if (m_pos[k] == m_len[k]) m_act[k] = 1'b0;
        end
        if (!m_act[k] && m_cnt[k] > 0) begin
            m_byte[k] = m_q[k][m_hd[k]];
            m_hd[k] = (m_hd[k] + 1) % 16;
            m_cnt[k]--;
            m_act[k] = 1'b1;
            m_pos[k] = 0;
            m_len[k] = (1 + dbits(k) + (pmode(k) != 0 ? 1 : 0) + sbits(k)) * SET;
        end
        if (f) begin
            m_q[k][(m_hd[k] + m_cnt[k]) % 16] = int'(dat[k]);
            m_cnt[k]++;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("serial%0d", k), 32'(ser[k]), m_act[k] ? 32'(frame_bit(k, m_byte[k], m_pos[k] / SET)) : 32'd1);
                check($sformatf("busy%0d", k), 32'(bsy[k]), 32'(m_act[k] || m_cnt[k] > 0));
                check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(m_cnt[k] < depth(k)));
            end
            check("count0", 32'(fc0), m_cnt[0]);
            check("count1", 32'(fc1), m_cnt[1]);
            check("count2", 32'(fc2), m_cnt[2]);
        end
    end

    task automatic push(input int k, input int b);
        vld[k] = 1'b1;
        dat[k] = 8'(b);
        @(negedge clk);
        vld[k] = 1'b0;
    endtask

    task automatic probe_frame(input int k, input string tag, input int bit_at, input logic bit_exp, input int len_exp);
        int t = 0;
        int n = 0;
        while (ser[k] !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_latency"}, t, 1);
        while (bsy[k] === 1'b1 && n < 400) begin
            if (n == bit_at) check({tag, "_bit"}, 32'(ser[k]), 32'(bit_exp));
            @(negedge clk);
            n++;
        end
        check({tag, "_len"}, n, len_exp);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while (bsy !== 3'b000 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(bsy), 0);
    endtask

    initial begin
        int acc;
        int c;
        logic got;
        for (int k = 0; k < 3; k++) dat[k] = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        reset = 1'b0;
        check("reset_serial", 32'(ser), 32'h7);
        check("reset_ready", 32'(rdy), 32'h7);
        check("reset_busy", 32'(bsy), 0);
        check("reset_count", 32'(fc0), 0);

        push(0, 'hA5);
        probe_frame(0, "t1_8n1", 55, 1'b0, 100);
        push(1, 'h55);
        probe_frame(1, "t2_7e2", 85, 1'b0, 110);
        push(2, 'h01);
        probe_frame(2, "t3_8o1", 95, 1'b0, 110);

        acc = 0;
        for (int i = 0; i < 6; i++) begin
            vld[0] = 1'b1;
            dat[0] = 8'(16 + acc);
            got = rdy[0];
            @(negedge clk);
            if (got) acc++;
        end
        check("t4_accepted", acc, 5);
        check("t4_ready_low", 32'(rdy[0]), 0);
        c = 0;
        while (acc < 6 && c < 300) begin
            dat[0] = 8'(16 + acc);
            got = rdy[0];
            @(negedge clk);
            if (got) acc++;
            c++;
        end
        vld[0] = 1'b0;
        check("t4_sixth", acc, 6);
        wait_idle("t4_drain", 1000);

        push(0, 'h61);
        push(0, 'h62);
        push(0, 'h63);
        check("t6_count_pre", 32'(fc0), 2);
        repeat (98) @(negedge clk);
        check("t6_count_hold", 32'(fc0), 2);
        push(0, 'h64);
        check("t6_pushpop", 32'(fc0), 2);
        wait_idle("t6_drain", 600);

        push(0, 'h71);
        push(0, 'h72);
        push(0, 'h73);
        push(0, 'h74);
        check("t5_queued", 32'(fc0), 3);
        repeat (32) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_serial", 32'(ser[0]), 1);
        check("t5_count", 32'(fc0), 0);
        check("t5_ready", 32'(rdy[0]), 1);
        check("t5_busy", 32'(bsy[0]), 0);
        reset = 1'b0;
        push(0, 'h3C);
        probe_frame(0, "t5_after", 55, 1'b1, 100);

        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 3; k++) begin
                vld[k] = $urandom_range(0, 99) < (i < 2000 ? 6 : 2);
                dat[k] = 8'($urandom);
            end
            @(negedge clk);
        end
        vld = '0;
        wait_idle("rand_drain", 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_transmitter_fifo.md
# uart_transmitter_fifo

Parametrised UART transmitter with configurable frame format (data bits, parity, stop bits) and an internal transmit FIFO. Bytes are pushed with a ready/valid handshake and serialised back-to-back, LSB first, on `serial_out`. The block sits between the CPU's memory-mapped UART registers and the FPGA TX pin. It replaces the fixed 8N1 single-buffer transmitter.

## Interface
Parameters:
- `CLOCK_FREQ`, 125_000_000: `clk` frequency in Hz.
- `BAUD_RATE`, 115_200: line rate; `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE` (integer division) clocks per bit.
- `DATA_BITS`, 8: payload bits per frame, legal 5..8.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `FIFO_DEPTH`, 8: entries, power of two, 2..16.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `data_in` in `DATA_BITS`: character to send.
- `data_in_valid` in 1: producer has a character.
- `data_in_ready` out 1: FIFO can accept; equals `!full`.
- `serial_out` out 1: TX line, idle high.
- `tx_busy` out 1: high while a frame is on the line or the FIFO is non-empty.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: current occupancy, 0..`FIFO_DEPTH`.

## Operation
- Write: `fire = data_in_valid & data_in_ready`. On a fire edge, `data_in` is written at the write pointer and the pointer advances mod `FIFO_DEPTH`.
- Full: `data_in_ready` is low. A pop in the same cycle does not make room for a write in that cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Each non-IDLE state holds its bit for `SYMBOL_EDGE_TIME` cycles, counted by a clock counter that clears on every state or bit change.
  - IDLE: `serial_out` = 1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `serial_out` = 0, then go to DATA with bit index 0.
  - DATA: `serial_out` = `shift[0]`. At the end of each bit, shift right and increment the index. After bit `DATA_BITS-1`, go to PARITY if `PARITY != 0`, else go to STOP.
  - PARITY: `serial_out` is the XOR of the popped payload for even parity, inverted for odd parity. Parity is computed at pop time and registered.
  - STOP: `serial_out` = 1 for `STOP_BITS` bit times. At the end: if the FIFO is non-empty, pop and go directly to START with no idle gap; else go to IDLE.
- Frame length is `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * SYMBOL_EDGE_TIME` cycles.
- Simultaneous push and pop when not full: both happen; `fifo_count` is unchanged.
- `data_in` bits above `DATA_BITS` do not exist; the payload is exactly `DATA_BITS` wide.

## Timing
- Reset values: `serial_out` = 1, `data_in_ready` = 1, `tx_busy` = 0, `fifo_count` = 0, state IDLE, pointers and counters 0.
- Reset mid-frame aborts the frame and flushes the FIFO. `serial_out` is high from the cycle after the reset edge.
- Latency, empty and idle: fire at edge N makes the FIFO non-empty after N. Pop happens at edge N+1, and the start bit is driven from edge N+1 through edge N+1+`SYMBOL_EDGE_TIME`.
- `fifo_count` updates on the edge after fire or pop. `data_in_ready` falls in the cycle after the write that fills the FIFO.
- `serial_out` is registered-state-derived only. It never glitches within a bit period.
- `tx_busy` drops the cycle after the final stop-bit edge, if the FIFO is empty.

## Test plan
Bench configuration: `CLOCK_FREQ`=1000 and `BAUD_RATE`=100, giving 10 clocks per bit.
1. 8N1, push 0xA5 once: line low 10 cycles starting 1 cycle after the fire edge, then 1,0,1,0,0,1,0,1 (LSB first), 10 cycles each, then high. Frame is 100 cycles; `tx_busy` falls after cycle 100.
2. `DATA_BITS`=7, `PARITY`=1, `STOP_BITS`=2, push 0x55: 4 ones give even parity bit 0. Frame is 110 cycles; line high for the final 20.
3. `PARITY`=2, push 0x01: parity bit is 0, since odd parity with one 1 is already odd.
4. `FIFO_DEPTH`=4, hold valid with 6 bytes 0x10..0x15: 5 accepted before ready drops (one popped, four queued). The sixth is accepted when the first frame ends and the next pop occurs. All six frames are back-to-back with no idle cycle between stop and start.
5. Assert reset at cycle 35 of a frame with 3 bytes queued: line high next cycle, `fifo_count` 0, `data_in_ready` 1. A new byte pushed afterwards transmits normally.
6. Push and pop in the same cycle at count 2: count stays 2 and the data order is preserved (FIFO order checked by the decoder).
